// File: rtl/dtack_berr_gen_if.sv
// 68008 bus-termination signal bundle: CPU strobes, decoded selects and device acks in,
// DTACK_n/BERR_n out. The master side is the CPU/decoder; the slave side is the terminator.
interface dtack_berr_gen_if;
  logic AS_n;
  logic DS_n;
  logic ROMSEL_n;
  logic RAMSEL1_n;
  logic DUASEL_n;
  logic EXPSEL_n;
  logic DUAIACK_n;
  logic DUADTACK_n;
  logic EXPDTACK_n;
  logic VPA_n;
  logic DTACK_n;
  logic BERR_n;

  modport master (
    output AS_n, DS_n, ROMSEL_n, RAMSEL1_n, DUASEL_n, EXPSEL_n,
    output DUAIACK_n, DUADTACK_n, EXPDTACK_n, VPA_n,
    input  DTACK_n, BERR_n
  );

  modport slave (
    input  AS_n, DS_n, ROMSEL_n, RAMSEL1_n, DUASEL_n, EXPSEL_n,
    input  DUAIACK_n, DUADTACK_n, EXPDTACK_n, VPA_n,
    output DTACK_n, BERR_n
  );
endinterface

// File: rtl/dtack_berr_gen.sv
// Bus-cycle terminator: programmable-wait or pass-through DTACK_n, watchdog BERR_n,
// and a saturating bus-error counter.
module dtack_berr_gen #(
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  dtack_berr_gen_if.slave  bus,
  output logic [CNT_W-1:0] BERR_CNT
);

  localparam int unsigned TMO_W = $clog2(BERR_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_ROM,
    SRC_RAM,
    SRC_DUA,
    SRC_EXP
  } src_e;

  state_e           state_q,    state_d;
  src_e             src_q,      src_d;
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic             armed_q,    armed_d;
  logic             dtack_n_q,  dtack_n_d;
  logic             berr_n_q,   berr_n_d;
  logic [CNT_W-1:0] berr_cnt_q, berr_cnt_d;

  logic ack_hit_c;
  src_e start_src_c;

  // Source priority at cycle start; later select changes are not looked at.
  always_comb begin
    start_src_c = SRC_NONE;
    if (!bus.ROMSEL_n)                         start_src_c = SRC_ROM;
    else if (!bus.RAMSEL1_n)                   start_src_c = SRC_RAM;
    else if (!bus.DUASEL_n || !bus.DUAIACK_n)  start_src_c = SRC_DUA;
    else if (!bus.EXPSEL_n)                    start_src_c = SRC_EXP;
  end

  // Acknowledge condition for the latched source while in WAIT.
  always_comb begin
    ack_hit_c = 1'b0;
    unique case (src_q)
      SRC_ROM, SRC_RAM: ack_hit_c = (wait_cnt_q == '0);
      SRC_DUA:          ack_hit_c = !bus.DUADTACK_n;
      SRC_EXP:          ack_hit_c = !bus.EXPDTACK_n;
      default:          ack_hit_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    armed_d    = armed_q;
    dtack_n_d  = 1'b1;
    berr_n_d   = 1'b1;
    berr_cnt_d = berr_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // A start needs a prior IDLE edge with AS_n high so a held strobe never re-triggers.
        if (bus.AS_n) begin
          armed_d = 1'b1;
        end else if (armed_q && !bus.DS_n) begin
          armed_d   = 1'b0;
          state_d   = ST_WAIT;
          src_d     = start_src_c;
          tmo_cnt_d = '0;
          unique case (start_src_c)
            SRC_ROM: wait_cnt_d = TMO_W'(ROM_WAIT);
            SRC_RAM: wait_cnt_d = TMO_W'(RAM_WAIT);
            default: wait_cnt_d = '0;
          endcase
        end
      end

      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - TMO_W'(1);
        // Abort beats autovector beats acknowledge beats timeout.
        if (bus.AS_n) begin
          state_d = ST_IDLE;
        end else if (!bus.VPA_n) begin
          state_d = ST_DONE;
        end else if (ack_hit_c) begin
          state_d   = ST_ACK;
          dtack_n_d = 1'b0;
        end else if (tmo_cnt_q == TMO_W'(BERR_TIMEOUT - 1)) begin
          state_d  = ST_BERR;
          berr_n_d = 1'b0;
          if (berr_cnt_q != {CNT_W{1'b1}}) berr_cnt_d = berr_cnt_q + CNT_W'(1);
        end
      end

      ST_ACK: begin
        if (bus.AS_n) state_d   = ST_IDLE;
        else          dtack_n_d = 1'b0;
      end

      ST_BERR: begin
        if (bus.AS_n) state_d  = ST_IDLE;
        else          berr_n_d = 1'b0;
      end

      ST_DONE: begin
        if (bus.AS_n) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      armed_q    <= 1'b0;
      dtack_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
      berr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      armed_q    <= armed_d;
      dtack_n_q  <= dtack_n_d;
      berr_n_q   <= berr_n_d;
      berr_cnt_q <= berr_cnt_d;
    end
  end

  assign bus.DTACK_n = dtack_n_q;
  assign bus.BERR_n  = berr_n_q;
  assign BERR_CNT    = berr_cnt_q;

endmodule

// File: doc/dtack_berr_gen.md
Name: dtack_berr_gen

Overview:
- Bus-cycle terminator downstream of the 68008 glue-logic address decoder.
- Consumes the decoded chip selects (ROMSEL_n, RAMSEL1_n, DUASEL_n, EXPSEL_n) and the CPU strobes.
- Produces DTACK_n, with per-device programmable wait states or a pass-through of device-driven acknowledges.
- Produces BERR_n from a watchdog when no device answers; keeps a saturating bus-error count for GPIO debug.

Parameters:
ROM_WAIT, 2, extra wait cycles before DTACK for ROM accesses (0..BERR_TIMEOUT-2)
RAM_WAIT, 0, extra wait cycles before DTACK for SRAM accesses (0..BERR_TIMEOUT-2)
BERR_TIMEOUT, 64, CLK cycles from cycle start to BERR assertion if no acknowledge (>=4)
CNT_W, 8, width of bus-error counter

Ports:
CLK  in  1  CPU clock; all logic on rising edge
RST_n  in  1  synchronous, active-low reset
AS_n  in  1  CPU address strobe
DS_n  in  1  CPU data strobe
ROMSEL_n  in  1  decoded ROM select
RAMSEL1_n  in  1  decoded SRAM select
DUASEL_n  in  1  decoded DUART select
EXPSEL_n  in  1  decoded expansion select
DUAIACK_n  in  1  DUART interrupt-acknowledge cycle in progress
DUADTACK_n  in  1  DTACK driven by DUART
EXPDTACK_n  in  1  DTACK driven by expansion card
VPA_n  in  1  autovector cycle in progress; cycle terminated by VPA, not by this block
DTACK_n  out  1  registered acknowledge to CPU
BERR_n  out  1  registered bus error to CPU
BERR_CNT  out  CNT_W  saturating count of bus errors since reset

Behaviour:
- Reset: RST_n sampled low at rising CLK. State=IDLE, DTACK_n=1, BERR_n=1, wait/timeout counters=0, BERR_CNT=0. Reset overrides any in-flight cycle; outputs are high on the next edge.
- All inputs are sampled on rising CLK. DTACK_n/BERR_n are driven only from flops; no combinational path from inputs.
- Cycle start: in IDLE, first edge with AS_n=0 and DS_n=0.
  - Source latched with priority ROM > RAM > DUA(DUASEL_n=0 or DUAIACK_n=0) > EXP > NONE.
  - Later chip-select changes within the same cycle are ignored.
- States:
  - IDLE: outputs high. On cycle start, go to WAIT. Load wait counter with ROM_WAIT/RAM_WAIT for internal sources. Clear timeout counter.
  - WAIT, internal source (ROM/RAM): wait counter decrements each edge. Go to ACK on the edge where it is 0. With start on edge N, DTACK_n goes low at edge N+1+WAIT.
  - WAIT, external source (DUA/EXP): go to ACK on the first edge with the corresponding *DTACK_n sampled low. DTACK_n goes low 1 cycle after the device asserts.
  - WAIT, source NONE: never acknowledges; only the timeout applies.
  - Timeout counter increments every edge in WAIT. When it reaches BERR_TIMEOUT-1: go to BERR, BERR_n=0, and BERR_CNT+1 saturating at 2^CNT_W-1.
  - ACK and timeout qualifying on the same edge: ACK wins; BERR not asserted.
  - VPA_n sampled low in WAIT: go to DONE with no DTACK and no BERR (autovector). DTACK_n and VPA_n are never low together from this block.
  - ACK: DTACK_n=0 held until AS_n sampled high, then IDLE with DTACK_n=1 on that same edge.
  - BERR: BERR_n=0 held until AS_n sampled high, then IDLE with BERR_n=1.
  - DONE: outputs high; go to IDLE when AS_n sampled high.
  - AS_n sampled high while in WAIT (aborted cycle): go to IDLE directly, outputs stay high, no count.
- DTACK_n and BERR_n are never low on the same cycle.
- Back-to-back cycles: a new start is only recognised after at least one IDLE edge with AS_n high.

Test Plan:
- ROM read, ROM_WAIT=2: AS_n/DS_n low with ROMSEL_n low at edge 10 -> DTACK_n low at edge 13, high on first edge AS_n sampled high; BERR_n stays 1.
- RAM read, RAM_WAIT=0: start at edge 5 -> DTACK_n low at edge 6. Toggle ROMSEL_n low at edge 5.5 -> no effect on latency.
- DUART access: DUASEL_n low, DUADTACK_n held high 7 cycles then low -> DTACK_n low exactly 1 edge later. Repeat with DUAIACK_n low and DUASEL_n high -> same result.
- Unmapped access: no select, BERR_TIMEOUT=64, start at edge 0 -> BERR_n low at edge 64, DTACK_n never low, BERR_CNT 0->1. Run 300 such cycles with CNT_W=8 -> BERR_CNT saturates at 255.
- Race and autovector: EXPDTACK_n low on the same edge the timeout expires -> DTACK_n low, BERR_n stays 1. VPA_n low in WAIT -> neither output asserts.
- Mid-cycle reset/abort: RST_n low during ROM WAIT -> DTACK_n=1, BERR_n=1, BERR_CNT=0 next edge. AS_n high during WAIT -> IDLE, no DTACK, BERR_CNT unchanged.
